hyperram_ctrl_responder: RTL

Synthesizable HyperRAM device model that attaches directly to the controller-side DDR word interface, in place of the FPGA I/O block plus a physical device.
- Decodes the 48-bit command/address (CA) and applies fixed 2x latency.
- Serves linear-burst reads and byte-masked writes from an internal word RAM; handles ID0/CR0 register accesses.
- Used for fast controller simulation and on-chip loopback without I/O timing.

---
 rtl/hyperram_dev_pkg.sv | 19 +
 rtl/hyperram_dev_mem.sv | 31 +++
 rtl/hyperram_ctrl_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hyperram_dev_pkg.sv
// Shared definitions for the HyperRAM device model: FSM states, CA field positions, CR0 default.
package hyperram_dev_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCa,
    StLat,
    StRd,
    StWr,
    StRegwr
  } state_e;

  localparam int unsigned CA_RW     = 47;
  localparam int unsigned CA_AS     = 46;
  localparam int unsigned CA_REGSEL = 24;

  localparam logic [15:0] CR0_RESET = 16'h8F1F;

endpackage

// File: rtl/hyperram_dev_mem.sv
// Single-port 16-bit word RAM with per-byte write enables and a registered read port.
module hyperram_dev_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_re,
  input  logic [1:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  output logic [15:0]       o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [15:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
    if (i_we[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/hyperram_ctrl_responder.sv
// HyperRAM device model on the controller's DDR word interface: CA decode, fixed 2x latency,
// linear-burst reads, byte-masked writes and ID0/CR0 register access.
module hyperram_ctrl_responder
  import hyperram_dev_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 6,
  parameter logic [15:0] ID0_VAL = 16'h0C81
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ctrl_rstn_i,
  input  logic [1:0]  ctrl_ck_ddr_i,
  input  logic        ctrl_csn_i,
  input  logic [15:0] ctrl_dq_ddr_out_i,
  input  logic        ctrl_dq_oe_i,
  input  logic [1:0]  ctrl_rwds_ddr_out_i,
  input  logic        ctrl_rwds_oe_i,
  output logic [15:0] ctrl_dq_ddr_in_o,
  output logic        ctrl_dq_ie_o,
  output logic [15:0] cr0_o
);

  localparam int unsigned CNT_W = $clog2(2 * LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_CYC = CNT_W'(2 * LATENCY);

  state_e            r_state;
  logic [47:16]      r_ca_hi;
  logic              r_ca_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_regwr_done;
  logic [15:0]       r_cr0;
  logic              r_ie;
  logic              r_rd_is_reg;
  logic [15:0]       r_reg_data;

  logic        w_abort;
  logic        w_active;
  logic [47:0] w_ca;
  logic [31:0] w_addr_full;
  logic        w_mem_re;
  logic [1:0]  w_mem_we;
  logic [15:0] w_mem_rdata;
  logic        w_unused;

  // csn high or device reset take priority over any active CK edge
  assign w_abort     = ctrl_csn_i || !ctrl_rstn_i;
  assign w_active    = (ctrl_ck_ddr_i == 2'b10) && !w_abort;
  assign w_ca        = {r_ca_hi, ctrl_dq_ddr_out_i};
  assign w_addr_full = {w_ca[44:16], w_ca[2:0]};
  assign w_unused    = ^{w_ca, w_addr_full};

  assign w_mem_re = w_active && (r_state == StRd) && !r_ca_hi[CA_AS];
  assign w_mem_we = (w_active && (r_state == StWr) && ctrl_dq_oe_i) ?
                    (ctrl_rwds_oe_i ? ~ctrl_rwds_ddr_out_i : 2'b11) : 2'b00;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_ca_hi      <= '0;
      r_ca_idx     <= 1'b0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_regwr_done <= 1'b0;
      r_cr0        <= CR0_RESET;
      r_ie         <= 1'b0;
      r_rd_is_reg  <= 1'b0;
      r_reg_data   <= '0;
    end else begin
      r_ie <= 1'b0;
      if (!ctrl_rstn_i) r_cr0 <= CR0_RESET;
      if (w_abort) begin
        r_state <= StIdle;
      end else if (w_active) begin
        case (r_state)
          StIdle: begin
            r_ca_hi[47:32] <= ctrl_dq_ddr_out_i;
            r_ca_idx       <= 1'b0;
            r_state        <= StCa;
          end
          StCa: begin
            if (!r_ca_idx) begin
              r_ca_hi[31:16] <= ctrl_dq_ddr_out_i;
              r_ca_idx       <= 1'b1;
            end else begin
              r_addr       <= w_addr_full[ADDR_W-1:0];
              r_regwr_done <= 1'b0;
              r_cnt        <= LAT_CYC;
              r_state      <= (!w_ca[CA_RW] && w_ca[CA_AS]) ? StRegwr : StLat;
            end
          end
          StLat: begin
            // Leaving on the last latency cycle puts the first data word at 3 + 2*LATENCY
            if (r_cnt == CNT_W'(1)) begin
              r_state <= r_ca_hi[CA_RW] ? StRd : StWr;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          StRd: begin
            r_ie        <= 1'b1;
            r_rd_is_reg <= r_ca_hi[CA_AS];
            r_reg_data  <= r_ca_hi[CA_REGSEL] ? r_cr0 : ID0_VAL;
            r_addr      <= r_addr + ADDR_W'(1);
          end
          StWr: begin
            if (ctrl_dq_oe_i) r_addr <= r_addr + ADDR_W'(1);
          end
          StRegwr: begin
            if (ctrl_dq_oe_i && !r_regwr_done) begin
              r_regwr_done <= 1'b1;
              if (r_ca_hi[CA_REGSEL]) r_cr0 <= ctrl_dq_ddr_out_i;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  hyperram_dev_mem #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_re   (w_mem_re),
    .i_we   (w_mem_we),
    .i_addr (r_addr),
    .i_wdata(ctrl_dq_ddr_out_i),
    .o_rdata(w_mem_rdata)
  );

  assign ctrl_dq_ddr_in_o = r_rd_is_reg ? r_reg_data : w_mem_rdata;
  assign ctrl_dq_ie_o     = r_ie;
  assign cr0_o            = r_cr0;

endmodule
